// File: rtl/router_input_buffer_if.sv
// rtl/router_input_buffer_if.sv - flit push and switch-allocator handshake bundle for one router input port
interface router_input_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int INFO_WIDTH = 2,
    parameter int DEPTH      = 4,
    parameter int WAIT_WIDTH = 4
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [INFO_WIDTH-1:0] in_info;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  sa_request;
    logic [INFO_WIDTH-1:0] sa_info;
    logic [ADDR_WIDTH-1:0] sa_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  sa_grant;
    logic [CNT_W-1:0]      fifo_count;
    logic [WAIT_WIDTH-1:0] hol_wait;

    modport master (
        output in_valid, in_info, in_addr, in_data, sa_grant,
        input  in_ready, sa_request, sa_info, sa_addr, out_data, fifo_count, hol_wait
    );

    modport slave (
        input  in_valid, in_info, in_addr, in_data, sa_grant,
        output in_ready, sa_request, sa_info, sa_addr, out_data, fifo_count, hol_wait
    );
endinterface

// File: rtl/router_input_buffer.sv
// rtl/router_input_buffer.sv - per-port flit FIFO with head-of-line request and wait counter
module router_input_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int INFO_WIDTH = 2,
    parameter int DEPTH      = 4,
    parameter int WAIT_WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    router_input_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_EMPTY   = 1'b0;
    localparam logic [0:0] ST_WAITING = 1'b1;

    localparam logic [CNT_W-1:0]      COUNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      COUNT_ONE  = CNT_W'(1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_MAX   = '1;

    logic [INFO_WIDTH-1:0] info_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [0:0]            state;
    logic [WAIT_WIDTH-1:0] hol;

    logic push;
    logic pop;

    // Handshakes depend only on the registered count, so no input-to-output path exists.
    assign bus.in_ready   = (count != COUNT_FULL);
    assign bus.sa_request = (count != '0);
    assign push           = bus.in_valid && bus.in_ready;
    assign pop            = bus.sa_grant && bus.sa_request;

    assign bus.sa_info    = info_mem[rd_ptr];
    assign bus.sa_addr    = addr_mem[rd_ptr];
    assign bus.out_data   = data_mem[rd_ptr];
    assign bus.fifo_count = count;
    assign bus.hol_wait   = hol;

    always_ff @(posedge clk) begin
        if (push) begin
            info_mem[wr_ptr] <= bus.in_info;
            addr_mem[wr_ptr] <= bus.in_addr;
            data_mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        state <= ST_WAITING;
                    end
                end
                default: begin
                    if (pop && !push && count == COUNT_ONE) begin
                        state <= ST_EMPTY;
                    end
                end
            endcase
        end
    end

    // Every pop hands the port a fresh head, which starts its wait from zero.
    always_ff @(posedge clk) begin
        if (rst || pop || state == ST_EMPTY) begin
            hol <= '0;
        end else if (bus.sa_request && !bus.sa_grant && hol != WAIT_MAX) begin
            hol <= hol + WAIT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_router_input_buffer.sv
// tb/tb_router_input_buffer.sv - self-checking bench for router_input_buffer
module tb_router_input_buffer;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0]  info;
        logic [7:0]  addr;
        logic [15:0] data;
    } flit_t;

    typedef struct {
        logic  r;
        logic  v;
        logic  g;
        flit_t f;
        logic  e_req;
        logic  e_ready;
        int    e_cnt;
        int    e_hol;
        flit_t e_head;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    flit_t mq[$];
    int    mhol = 0;

    router_input_buffer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .INFO_WIDTH(2), .DEPTH(DEPTH), .WAIT_WIDTH(4)) bus ();

    router_input_buffer #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .INFO_WIDTH(2), .DEPTH(DEPTH), .WAIT_WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: a plain queue of flits plus a wait counter, updated from pre-edge values.
    task automatic step(input logic r, input logic v, input logic g, input flit_t f);
        bit acc;
        bit pp;
        int pre;
        rst          = r;
        bus.in_valid = v;
        bus.sa_grant = g;
        bus.in_info  = f.info;
        bus.in_addr  = f.addr;
        bus.in_data  = f.data;
        pre = mq.size();
        acc = v && (pre != DEPTH);
        pp  = g && (pre != 0);
        if (r) begin
            mq.delete();
            mhol = 0;
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(f);
            if (pp || pre == 0) mhol = 0;
            else if (!g && mhol < 15) mhol++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(mq.size() != DEPTH));
        chk({tag, ".sa_request"}, 32'(bus.sa_request), 32'(mq.size() != 0));
        chk({tag, ".fifo_count"}, 32'(bus.fifo_count), 32'(mq.size()));
        chk({tag, ".hol_wait"}, 32'(bus.hol_wait), 32'(mhol));
        if (mq.size() != 0) begin
            chk({tag, ".head"}, 32'({bus.sa_info, bus.sa_addr, bus.out_data}), 32'(mq[0]));
        end
    endtask

    function automatic flit_t mk(input int info, input int addr, input int data);
        flit_t f;
        f.info = 2'(info);
        f.addr = 8'(addr);
        f.data = 16'(data);
        return f;
    endfunction

    vec_t tbl[10];
    flit_t z;

    initial begin
        logic [7:0] wrap_addr[5];
        z = '0;
        // r v g flit | req ready cnt hol head
        tbl[0] = '{1'b1, 1'b0, 1'b0, z,                         1'b0, 1'b1, 0, 0, z};
        tbl[1] = '{1'b0, 1'b1, 1'b0, mk(1, 'h12, 'hABCD),      1'b1, 1'b1, 1, 0, mk(1, 'h12, 'hABCD)};
        tbl[2] = '{1'b0, 1'b1, 1'b0, mk(2, 'h34, 'h1111),      1'b1, 1'b1, 2, 1, mk(1, 'h12, 'hABCD)};
        tbl[3] = '{1'b0, 1'b1, 1'b0, mk(3, 'h56, 'h2222),      1'b1, 1'b1, 3, 2, mk(1, 'h12, 'hABCD)};
        tbl[4] = '{1'b0, 1'b1, 1'b0, mk(0, 'h78, 'h3333),      1'b1, 1'b0, 4, 3, mk(1, 'h12, 'hABCD)};
        tbl[5] = '{1'b0, 1'b1, 1'b0, mk(1, 'h9A, 'h4444),      1'b1, 1'b0, 4, 4, mk(1, 'h12, 'hABCD)};
        tbl[6] = '{1'b0, 1'b1, 1'b0, mk(1, 'h9A, 'h4444),      1'b1, 1'b0, 4, 5, mk(1, 'h12, 'hABCD)};
        tbl[7] = '{1'b0, 1'b1, 1'b0, mk(1, 'h9A, 'h4444),      1'b1, 1'b0, 4, 6, mk(1, 'h12, 'hABCD)};
        tbl[8] = '{1'b0, 1'b1, 1'b1, mk(1, 'h9A, 'h4444),      1'b1, 1'b1, 3, 0, mk(2, 'h34, 'h1111)};
        tbl[9] = '{1'b0, 1'b1, 1'b0, mk(1, 'h9A, 'h4444),      1'b1, 1'b0, 4, 1, mk(2, 'h34, 'h1111)};

        bus.in_valid = 1'b0;
        bus.sa_grant = 1'b0;
        bus.in_info  = '0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].g, tbl[i].f);
            chk($sformatf("tbl%0d.sa_request", i), 32'(bus.sa_request), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d.in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d.fifo_count", i), 32'(bus.fifo_count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.hol_wait", i), 32'(bus.hol_wait), 32'(tbl[i].e_hol));
            if (tbl[i].e_req) begin
                chk($sformatf("tbl%0d.head", i), 32'({bus.sa_info, bus.sa_addr, bus.out_data}), 32'(tbl[i].e_head));
            end
        end
        // Drain in arrival order.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, z);
            check_model($sformatf("drain%0d", i));
        end

        // Concurrent push and pop at count=2 across the pointer wrap.
        wrap_addr = '{8'h11, 8'h00, 8'h01, 8'h02, 8'h03};
        step(1'b1, 1'b0, 1'b0, z);
        step(1'b0, 1'b1, 1'b0, mk(0, 'h10, 'h0100));
        step(1'b0, 1'b1, 1'b0, mk(1, 'h11, 'h0101));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, mk(i, i, 'h2000 + i));
            chk($sformatf("wrap%0d.fifo_count", i), 32'(bus.fifo_count), 32'd2);
            chk($sformatf("wrap%0d.sa_addr", i), 32'(bus.sa_addr), 32'(wrap_addr[i]));
            check_model($sformatf("wrap%0d", i));
        end

        // Head-of-line wait saturation and clear on grant.
        step(1'b1, 1'b0, 1'b0, z);
        step(1'b0, 1'b1, 1'b0, mk(2, 'h44, 'h5555));
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, z);
        chk("hol.saturated", 32'(bus.hol_wait), 32'd15);
        step(1'b0, 1'b0, 1'b1, z);
        chk("hol.cleared", 32'(bus.hol_wait), 32'd0);
        chk("hol.count", 32'(bus.fifo_count), 32'd0);

        // Grant on empty is ignored; reset overrides push with flits buffered.
        step(1'b0, 1'b0, 1'b1, z);
        chk("empty_grant.count", 32'(bus.fifo_count), 32'd0);
        step(1'b0, 1'b1, 1'b0, mk(3, 'hC3, 'hBEEF));
        check_model("after_empty_grant");
        step(1'b0, 1'b1, 1'b0, mk(1, 'hC4, 'h1234));
        step(1'b0, 1'b1, 1'b0, mk(2, 'hC5, 'h5678));
        chk("pre_rst.count", 32'(bus.fifo_count), 32'd3);
        step(1'b1, 1'b1, 1'b1, mk(0, 'hC6, 'h9999));
        chk("rst.count", 32'(bus.fifo_count), 32'd0);
        chk("rst.sa_request", 32'(bus.sa_request), 32'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 45),
                 mk($urandom, $urandom, $urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
